// File: rtl/exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl
//
// MEM-stage exception detector and commit controller feeding the CP0 register
// file. External interrupt lines are synchronised, combined with the timer and
// software interrupt bits, and masked by Status. The highest-priority event of
// the MEM instruction is committed to CP0 with a one-cycle strobe, followed by
// a fixed-length pipeline flush that redirects fetch to the exception vector
// (or to EPC for ERET).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   int_i[5:0]            asynchronous hardware interrupt lines
//   timer_int_i           CP0 timer interrupt (already synchronous)
//   status_i, cause_i     CP0 Status (IE, EXL, IM) and Cause (software IP)
//   epc_i                 CP0 EPC, redirect target for ERET
//   mem_valid_i           a real instruction occupies MEM
//   mem_pc_i              PC of the MEM instruction
//   mem_in_delayslot_i    MEM instruction sits in a delay slot
//   mem_exc_i[7:0]        per-instruction exception flags
//   mem_is_store_i        selects AdES (1) / AdEL (0) for the data flag
//   mem_addr_i            data address of the MEM load/store
//   stall_i               MEM stalled, commit is held off
//   cp0_en_o              one-cycle commit strobe
//   excepttype_o          committed exception code
//   current_inst_addr_o   committed PC
//   is_in_delayslot_o     committed delay-slot bit
//   bad_addr_o            committed BadVAddr
//   flush_o               pipeline flush request
//   newpc_o               redirect target, valid while flush_o=1
//   int_pending_o         registered unmasked-interrupt request
// -----------------------------------------------------------------------------
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_exc_i,
  input  logic        mem_is_store_i,
  input  logic [31:0] mem_addr_i,
  input  logic        stall_i,
  output logic        cp0_en_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        int_pending_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q;
  logic [SYNC_STAGES-1:0][5:0]        sync_q;
  logic [5:0]                         hw_ip;
  logic [7:0]                         ip;
  logic                               int_req;
  logic                               evt_valid;
  logic [4:0]                         evt_code;
  logic [31:0]                        evt_bad;
  logic                               commit;

  // Only a subset of the CP0 register bits matters here.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2],
                             cause_i[31:10], cause_i[7:0]};

  // NOTE: flops with no architectural reset value would be legal here, but the
  // synchroniser is cleared so no stale interrupt survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so every stage samples the previous
      // stage's pre-edge value, giving a true shift register.
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_i};
    end
  end

  // Timer interrupt shares IP7 with hardware line 5.
  assign hw_ip   = {sync_q[SYNC_STAGES-1][5] | timer_int_i, sync_q[SYNC_STAGES-1][4:0]};
  assign ip      = {hw_ip, cause_i[9:8]};
  assign int_req = status_i[0] & ~status_i[1] & (|(ip & status_i[15:8]));

  // Priority select of the MEM instruction's event.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    evt_valid = 1'b0;
    evt_code  = 5'h00;
    evt_bad   = '0;
    if (mem_valid_i) begin
      evt_valid = 1'b1;
      if (int_req)            evt_code = EXC_INT;
      else if (mem_exc_i[0]) begin
        evt_code = EXC_ADEL;
        evt_bad  = mem_pc_i;
      end
      else if (mem_exc_i[1])  evt_code = EXC_RI;
      else if (mem_exc_i[2])  evt_code = EXC_OV;
      else if (mem_exc_i[3])  evt_code = EXC_TR;
      else if (mem_exc_i[4])  evt_code = EXC_SYS;
      else if (mem_exc_i[5])  evt_code = EXC_BP;
      else if (mem_exc_i[7]) begin
        evt_code = mem_is_store_i ? EXC_ADES : EXC_ADEL;
        evt_bad  = mem_addr_i;
      end
      else if (mem_exc_i[6])  evt_code = EXC_ERET;
      else                    evt_valid = 1'b0;
    end
  end

  // Next-state logic; the counter holds the remaining FLUSH cycles.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (evt_valid && !stall_i) begin
          state_d = S_COMMIT;
          commit  = 1'b1;
        end
      end
      S_COMMIT: state_d = (cnt_q != '0) ? S_FLUSH : S_IDLE;
      S_FLUSH:  if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Derived from the state register, so both drop with an async reset.
  assign cp0_en_o = (state_q == S_COMMIT);
  assign flush_o  = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= S_IDLE;
      cnt_q               <= '0;
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= '0;
      newpc_o             <= '0;
      int_pending_o       <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pending_o <= int_req;
      if (commit) begin
        cnt_q               <= CNT_W'(FLUSH_CYCLES - 1);
        excepttype_o        <= {27'b0, evt_code};
        current_inst_addr_o <= mem_pc_i;
        is_in_delayslot_o   <= mem_in_delayslot_i;
        bad_addr_o          <= evt_bad;
        newpc_o             <= (evt_code == EXC_ERET) ? epc_i : EXC_VECTOR;
      end else if (state_q == S_FLUSH && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for exc_commit_ctrl: table-driven priority vectors, hand-written
// multi-cycle sequences, and randomized traffic compared every cycle against
// a behavioural model (interrupt history queue + remaining-flush counter).
// -----------------------------------------------------------------------------
module tb_exc_commit_ctrl;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;
  localparam int          FLUSH_CYCLES = 2;
  localparam int          SYNC_STAGES  = 2;

  logic        clk, rst;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [7:0]  mem_exc_i;
  logic        mem_is_store_i;
  logic [31:0] mem_addr_i;
  logic        stall_i;
  logic        cp0_en_o;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, flush_o, int_pending_o;

  exc_commit_ctrl #(
    .EXC_VECTOR(EXC_VECTOR), .FLUSH_CYCLES(FLUSH_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .timer_int_i(timer_int_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_exc_i(mem_exc_i),
    .mem_is_store_i(mem_is_store_i), .mem_addr_i(mem_addr_i), .stall_i(stall_i),
    .cp0_en_o(cp0_en_o), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .newpc_o(newpc_o),
    .int_pending_o(int_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0]  m_hist[$];      // int_i seen at past edges, newest first
  int          m_flush_left;   // flush cycles still to come
  logic        m_en, m_pend, m_ds;
  logic [31:0] m_code, m_addr, m_bad, m_newpc;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(6'b0);
    m_flush_left = 0;
    m_en = 1'b0; m_pend = 1'b0; m_ds = 1'b0;
    m_code = '0; m_addr = '0; m_bad = '0; m_newpc = '0;
  endtask

  task automatic model_edge();
    int          order [8] = '{0, 1, 2, 3, 4, 5, 7, 6};
    int          codes [8] = '{4, 10, 12, 13, 8, 9, 14, 4};
    logic [5:0]  s;
    logic [7:0]  ip;
    logic        ireq;
    int          code, b;
    logic [31:0] bad;
    s    = m_hist[SYNC_STAGES-1];
    ip   = {s[5] | timer_int_i, s[4:0], cause_i[9:8]};
    ireq = status_i[0] & ~status_i[1] & ((ip & status_i[15:8]) != 8'h0);
    code = -1;
    bad  = '0;
    if (mem_valid_i) begin
      if (ireq) code = 1;
      else begin
        for (int k = 0; k < 8; k++) begin
          b = order[k];
          if (code < 0 && mem_exc_i[b]) begin
            code = (b == 7) ? (mem_is_store_i ? 5 : 4) : codes[b];
            bad  = (b == 0) ? mem_pc_i : (b == 7) ? mem_addr_i : 32'h0;
          end
        end
      end
    end
    if (m_flush_left == 0 && code >= 0 && !stall_i) begin
      m_en         = 1'b1;
      m_code       = 32'(code);
      m_addr       = mem_pc_i;
      m_ds         = mem_in_delayslot_i;
      m_bad        = bad;
      m_newpc      = (code == 14) ? epc_i : EXC_VECTOR;
      m_flush_left = FLUSH_CYCLES;
    end else begin
      m_en = 1'b0;
      if (m_flush_left > 0) m_flush_left--;
    end
    m_pend = ireq;
    m_hist.push_front(int_i);
    void'(m_hist.pop_back());
  endtask

  task automatic check_all();
    check("m.cp0_en",   cp0_en_o,            m_en);
    check("m.flush",    flush_o,             m_flush_left > 0);
    check("m.code",     excepttype_o,        m_code);
    check("m.addr",     current_inst_addr_o, m_addr);
    check("m.ds",       is_in_delayslot_o,   m_ds);
    check("m.bad",      bad_addr_o,          m_bad);
    check("m.newpc",    newpc_o,             m_newpc);
    check("m.pending",  int_pending_o,       m_pend);
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    int_i = '0; timer_int_i = 1'b0; status_i = '0; cause_i = '0; epc_i = '0;
    mem_valid_i = 1'b0; mem_pc_i = '0; mem_in_delayslot_i = 1'b0; mem_exc_i = '0;
    mem_is_store_i = 1'b0; mem_addr_i = '0; stall_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  exc;
    logic        store;
    logic        timer;
    logic [31:0] exp_code;
    logic [31:0] exp_bad;
    logic [31:0] exp_newpc;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic en_seen;

    // pc = BFC00100, addr = 10000008, epc = 80000180 for every vector
    vecs[0]  = '{8'h10, 1'b0, 1'b0, 32'h8, 32'h0,        EXC_VECTOR};
    vecs[1]  = '{8'h01, 1'b0, 1'b0, 32'h4, 32'hBFC00100, EXC_VECTOR};
    vecs[2]  = '{8'h02, 1'b0, 1'b0, 32'ha, 32'h0,        EXC_VECTOR};
    vecs[3]  = '{8'h04, 1'b0, 1'b0, 32'hc, 32'h0,        EXC_VECTOR};
    vecs[4]  = '{8'h08, 1'b0, 1'b0, 32'hd, 32'h0,        EXC_VECTOR};
    vecs[5]  = '{8'h20, 1'b0, 1'b0, 32'h9, 32'h0,        EXC_VECTOR};
    vecs[6]  = '{8'h80, 1'b0, 1'b0, 32'h4, 32'h10000008, EXC_VECTOR};
    vecs[7]  = '{8'h80, 1'b1, 1'b0, 32'h5, 32'h10000008, EXC_VECTOR};
    vecs[8]  = '{8'h40, 1'b0, 1'b0, 32'he, 32'h0,        32'h80000180};
    vecs[9]  = '{8'hFF, 1'b1, 1'b0, 32'h4, 32'hBFC00100, EXC_VECTOR};
    vecs[10] = '{8'hFE, 1'b1, 1'b0, 32'ha, 32'h0,        EXC_VECTOR};
    vecs[11] = '{8'hC0, 1'b1, 1'b0, 32'h5, 32'h10000008, EXC_VECTOR};
    vecs[12] = '{8'h30, 1'b0, 1'b0, 32'h8, 32'h0,        EXC_VECTOR};
    vecs[13] = '{8'hFF, 1'b0, 1'b1, 32'h1, 32'h0,        EXC_VECTOR};

    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset cp0_en", cp0_en_o, 1'b0);
    check("reset flush", flush_o, 1'b0);
    check("reset code", excepttype_o, 32'h0);
    check("reset newpc", newpc_o, 32'h0);
    check("reset pending", int_pending_o, 1'b0);
    rst = 1'b0;
    tick();

    // ---- priority table ----
    for (int i = 0; i < 14; i++) begin
      status_i = 32'h00008001;
      epc_i = 32'h80000180; mem_pc_i = 32'hBFC00100; mem_addr_i = 32'h10000008;
      mem_valid_i = 1'b1;
      mem_exc_i = vecs[i].exc; mem_is_store_i = vecs[i].store; timer_int_i = vecs[i].timer;
      tick();
      check($sformatf("vec%0d cp0_en", i), cp0_en_o, 1'b1);
      check($sformatf("vec%0d code", i), excepttype_o, vecs[i].exp_code);
      check($sformatf("vec%0d bad", i), bad_addr_o, vecs[i].exp_bad);
      check($sformatf("vec%0d newpc", i), newpc_o, vecs[i].exp_newpc);
      check($sformatf("vec%0d addr", i), current_inst_addr_o, 32'hBFC00100);
      check($sformatf("vec%0d flush0", i), flush_o, 1'b1);
      mem_valid_i = 1'b0; timer_int_i = 1'b0;
      tick();
      check($sformatf("vec%0d flush1", i), flush_o, 1'b1);
      check($sformatf("vec%0d en1", i), cp0_en_o, 1'b0);
      tick();
      check($sformatf("vec%0d flush_end", i), flush_o, 1'b0);
    end
    idle_inputs();
    tick();

    // ---- synchronised interrupt overrides RI ----
    status_i = 32'h0000FF01;
    int_i = 6'b000100;
    tick(); check("int lat1", int_pending_o, 1'b0);
    tick(); check("int lat2", int_pending_o, 1'b0);
    mem_valid_i = 1'b1; mem_exc_i = 8'h02; mem_pc_i = 32'hBFC00200;
    tick();
    check("int lat3", int_pending_o, 1'b1);
    check("int cp0_en", cp0_en_o, 1'b1);
    check("int code", excepttype_o, 32'h1);
    int_i = '0; mem_valid_i = 1'b0; mem_exc_i = '0;
    repeat (3) tick();
    status_i = '0;
    repeat (2) tick();

    // ---- EXL masks interrupts; timer with IM7 ----
    status_i = 32'h0000FF03; int_i = 6'b000100; mem_valid_i = 1'b1;
    en_seen = 1'b0;
    repeat (4) begin
      tick();
      en_seen |= cp0_en_o | int_pending_o;
    end
    check("exl no commit/pending", en_seen, 1'b0);
    int_i = '0;
    repeat (3) tick();
    status_i = 32'h00008001; timer_int_i = 1'b1;
    tick();
    check("timer cp0_en", cp0_en_o, 1'b1);
    check("timer code", excepttype_o, 32'h1);
    timer_int_i = 1'b0; mem_valid_i = 1'b0; status_i = '0;
    repeat (3) tick();

    // ---- stalled data load error ----
    mem_valid_i = 1'b1; mem_exc_i = 8'h80; mem_is_store_i = 1'b0;
    mem_addr_i = 32'h00000003; stall_i = 1'b1;
    en_seen = 1'b0;
    repeat (4) begin
      tick();
      en_seen |= cp0_en_o;
    end
    check("stall no commit", en_seen, 1'b0);
    stall_i = 1'b0;
    tick();
    check("stall cp0_en", cp0_en_o, 1'b1);
    check("stall code", excepttype_o, 32'h4);
    check("stall bad", bad_addr_o, 32'h3);
    mem_valid_i = 1'b0; mem_exc_i = '0;
    tick();
    check("stall single strobe", cp0_en_o, 1'b0);
    tick();

    // ---- ERET, then an exception offered during the flush ----
    mem_valid_i = 1'b1; mem_exc_i = 8'h40; mem_in_delayslot_i = 1'b1;
    epc_i = 32'h80001234; mem_pc_i = 32'hBFC00300;
    tick();
    check("eret code", excepttype_o, 32'he);
    check("eret newpc", newpc_o, 32'h80001234);
    check("eret ds", is_in_delayslot_o, 1'b1);
    mem_exc_i = 8'h10; mem_in_delayslot_i = 1'b0;
    tick();
    check("flush ignores cp0_en", cp0_en_o, 1'b0);
    check("flush ignores flush", flush_o, 1'b1);
    mem_valid_i = 1'b0; mem_exc_i = '0;
    tick();
    check("eret flush done", flush_o, 1'b0);
    check("eret code held", excepttype_o, 32'he);
    tick();

    // ---- reset during FLUSH ----
    mem_valid_i = 1'b1; mem_exc_i = 8'h10; mem_pc_i = 32'hBFC00200;
    tick();
    mem_valid_i = 1'b0; mem_exc_i = '0;
    tick();
    check("pre-rst flush", flush_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst flush async", flush_o, 1'b0);
    check("rst cp0_en async", cp0_en_o, 1'b0);
    check("rst code async", excepttype_o, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_valid_i = 1'b1; mem_exc_i = 8'h10; mem_pc_i = 32'hBFC00200;
    tick();
    check("post-rst cp0_en", cp0_en_o, 1'b1);
    check("post-rst code", excepttype_o, 32'h8);
    check("post-rst addr", current_inst_addr_o, 32'hBFC00200);
    idle_inputs();
    repeat (2) tick();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) int_i = 6'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        status_i = {16'h0, 8'($urandom), 6'h0,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
        cause_i  = {22'h0, 2'($urandom_range(0, 3) == 0 ? $urandom : 0), 8'h0};
      end
      timer_int_i        = ($urandom_range(0, 19) == 0);
      epc_i              = $urandom;
      mem_valid_i        = ($urandom_range(0, 9) < 7);
      mem_pc_i           = $urandom;
      mem_addr_i         = $urandom;
      mem_in_delayslot_i = 1'($urandom);
      mem_is_store_i     = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       mem_exc_i = '0;
        1:       mem_exc_i = 8'($urandom);
        default: mem_exc_i = 8'(1 << $urandom_range(0, 7));
      endcase
      stall_i = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
MEM-stage exception detector and commit controller sitting directly upstream of the CP0 register file. It synchronises external interrupt lines, prioritises per-instruction exception flags, and issues a one-cycle registered commit (en/excepttype/EPC source/delay-slot/bad address) to CP0. It then drives a timed pipeline flush with the redirect PC: the exception vector, or EPC for ERET.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC for all exceptions and interrupts
FLUSH_CYCLES, 2, number of cycles flush_o stays high per commit (>=1)
SYNC_STAGES, 2, flip-flop depth of the int_i synchroniser (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
int_i  in  6  asynchronous external hardware interrupts
timer_int_i  in  1  CP0 timer interrupt, synchronous
status_i  in  32  CP0 Status (bit0 IE, bit1 EXL, [15:8] IM)
cause_i  in  32  CP0 Cause ([9:8] software IP)
epc_i  in  32  CP0 EPC
mem_valid_i  in  1  a real instruction occupies MEM
mem_pc_i  in  32  PC of the MEM instruction
mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
mem_exc_i  in  8  flags: [0] fetch AdEL, [1] RI, [2] Ov, [3] trap, [4] syscall, [5] break, [6] eret, [7] data access error
mem_is_store_i  in  1  qualifies flag [7]: 1=AdES, 0=AdEL
mem_addr_i  in  32  data address of the MEM load/store
stall_i  in  1  MEM stalled (cache miss); no commit while high
cp0_en_o  out  1  one-cycle commit strobe to CP0
excepttype_o  out  32  commit code
current_inst_addr_o  out  32  PC sent to CP0
is_in_delayslot_o  out  1  delay-slot bit sent to CP0
bad_addr_o  out  32  BadVAddr value
flush_o  out  1  pipeline flush request
newpc_o  out  32  redirect target, valid while flush_o=1
int_pending_o  out  1  unmasked interrupt pending, registered

Behaviour:
- Reset: async and immediate. All outputs are 0, synchroniser flops are 0, FSM=IDLE, flush counter=0.
- Synchroniser: int_i passes through SYNC_STAGES flops. hw_ip[5:0] = {sync[5] | timer_int_i, sync[4:0]}. ip = {hw_ip, cause_i[9:8]}.
- int_req = status_i[0] & ~status_i[1] & |(ip & status_i[15:8]). int_pending_o is int_req registered each cycle.
- Event detect (combinational, IDLE only, requires mem_valid_i=1): code = first match in this order:
  - interrupt 0x1
  - fetch AdEL 0x4
  - RI 0xa
  - Ov 0xc
  - trap 0xd
  - syscall 0x8
  - break 0x9
  - data flag: 0x5 if store else 0x4
  - eret 0xe
- No valid event: no action.
- bad_addr: mem_pc_i for fetch AdEL, mem_addr_i for the data flag, otherwise 0.
- FSM IDLE -> COMMIT on a clock edge with an event and stall_i=0. That edge registers code, mem_pc_i, mem_in_delayslot_i and bad_addr into the outputs. newpc_o = epc_i if code=0xe, else EXC_VECTOR.
- Event with stall_i=1: remain in IDLE and re-evaluate every cycle. The interrupt may appear or disappear meanwhile; nothing is latched.
- COMMIT (1 cycle): cp0_en_o=1 and flush_o=1, load counter=FLUSH_CYCLES-1. Next state is FLUSH if the counter is >0, else IDLE.
- FLUSH: flush_o=1, counter decrements, exit to IDLE after the counter reaches 0. cp0_en_o=0.
- Total flush_o high time is exactly FLUSH_CYCLES cycles, starting in the cycle after detection.
- In COMMIT/FLUSH all mem_* inputs are ignored; stall_i does not extend the flush.
- cp0_en_o is low in every state except COMMIT. excepttype_o holds its last value and is meaningful only while cp0_en_o=1.
- newpc_o holds its value until the next commit.
- rst asserted mid-COMMIT/FLUSH: immediate IDLE, flush_o and cp0_en_o drop asynchronously.

Test Plan:
- Reset, then mem_valid=1 with mem_exc=8'h10 (syscall), delayslot=0, pc=32'hBFC00100. Required: next cycle cp0_en_o=1, excepttype=0x8, addr=32'hBFC00100. flush_o high 2 cycles, newpc=32'hBFC00380.
- status=32'h0000FF01, int_i[2] pulse held for 3 cycles, plus RI on a valid instruction. Required: int_pending_o rises 3 cycles after int_i (2 sync + 1 register). The commit then has code 0x1, overriding RI.
- Same interrupt with status EXL=1 (32'h0000FF03). Required: int_pending_o=0 and no commit. Raising timer_int_i with IM[7]=1 and EXL=0 gives code 0x1.
- Load with flag[7]=1, store=0, addr=32'h00000003, stall_i=1 for 4 cycles. Required: no cp0_en_o while stalled. After stall_i falls: one strobe with code 0x4 and bad_addr=32'h3.
- ERET with epc_i=32'h80001234, delayslot=1. Required: code 0xe and newpc=32'h80001234. A second exception presented during FLUSH is ignored.
- Assert rst in the FLUSH cycle. Required: flush_o=0 in the same cycle, and a subsequent syscall commits normally.
